// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions, the fill word,
// and the instruction-memory load FSM states.
package cpu_pkg;

  localparam logic [7:0] OP_FORWARD     = 8'd0;
  localparam logic [7:0] OP_ADD         = 8'd1;
  localparam logic [7:0] OP_SUB         = 8'd2;
  localparam logic [7:0] OP_AND         = 8'd3;
  localparam logic [7:0] OP_OR          = 8'd4;
  localparam logic [7:0] OP_RESERVED_LO = 8'd5;
  localparam logic [7:0] OP_RESERVED_HI = 8'd7;

  localparam int FIELD_W  = 8;
  localparam int OP_LSB   = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  // Reserved opcode with all-zero operands: the cpu treats it as a NOP.
  localparam logic [31:0] FILL_WORD_DEFAULT = {OP_RESERVED_HI, 24'h00_0000};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_READY
  } state_t;

  function automatic logic [7:0] opcode_of(input logic [31:0] instr);
    return instr[OP_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch and program-load signals between the cpu/loader (master) and the
// instruction-memory responder (slave).
interface instr_mem_responder_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [31:0]     PC;
  logic [31:0]     INSTRUCTION;
  logic            INSTR_VALID;
  logic            MISALIGN;
  logic            LOAD_START;
  logic            LOAD_VALID;
  logic [31:0]     LOAD_DATA;
  logic            LOAD_LAST;
  logic            LOAD_READY;
  logic [ADDR_W:0] PROG_LEN;

  modport master (
    output PC, LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST,
    input  INSTRUCTION, INSTR_VALID, MISALIGN, LOAD_READY, PROG_LEN
  );

  modport slave (
    input  PC, LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST,
    output INSTRUCTION, INSTR_VALID, MISALIGN, LOAD_READY, PROG_LEN
  );

endinterface

// File: rtl/instr_mem_responder_imem_ram.sv
// DEPTH x 32 program store: one write port and one registered read port.
module imem_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; stale words are masked by PROG_LEN upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: streams a program into imem_ram, then serves
// cpu fetches with one cycle of latency once a complete program is present.
module instr_mem_responder
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] FILL_WORD = FILL_WORD_DEFAULT
) (
  input logic                  CLK,
  input logic                  RESET,
  instr_mem_responder_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              load_ready;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] widx;
  logic              fetch_hit;
  logic              hit_q;
  logic              misalign_q;
  logic [31:0]       ram_rdata;

  assign load_ready = (state_q == ST_LOADING);
  // A word arriving alongside LOAD_START belongs to the discarded program.
  assign accept     = bus.LOAD_VALID && load_ready && !bus.LOAD_START;
  assign widx       = bus.PC[ADDR_W+1:2];

  assign fetch_hit = (state_q == ST_READY)
                  && (bus.PC[1:0] == 2'b00)
                  && ((bus.PC >> (ADDR_W + 2)) == 32'd0)
                  && ({1'b0, widx} < prog_len_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
      hit_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      hit_q      <= fetch_hit;
      misalign_q <= |bus.PC[1:0];
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    wr_en      = 1'b0;
    unique case (state_q)
      ST_EMPTY, ST_READY: begin
        if (bus.LOAD_START) begin
          state_d    = ST_LOADING;
          wptr_d     = '0;
          prog_len_d = '0;
        end
      end
      ST_LOADING: begin
        if (bus.LOAD_START) begin
          wptr_d = '0;
        end else if (accept) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (bus.LOAD_LAST || (wptr_q == ADDR_W'(DEPTH - 1))) begin
            state_d    = ST_READY;
            prog_len_d = {1'b0, wptr_q} + (ADDR_W + 1)'(1);
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_data (bus.LOAD_DATA),
    .rd_addr (widx),
    .rd_data (ram_rdata)
  );

  assign bus.INSTRUCTION = hit_q ? ram_rdata : FILL_WORD;
  assign bus.INSTR_VALID = hit_q;
  assign bus.MISALIGN    = misalign_q;
  assign bus.LOAD_READY  = load_ready;
  assign bus.PROG_LEN    = prog_len_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a queue-based program model.
module tb_instr_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] FILL  = 32'h0700_0000;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  instr_mem_responder_if #(.DEPTH(DEPTH)) bus ();

  instr_mem_responder #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Model: the readable program and the words collected by the load in progress.
  logic [31:0] prog [$];
  logic [31:0] pend [$];
  bit          loading = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: predict the fetch from pre-edge model state, advance, compare, update model.
  task automatic cycle();
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] pc;
    pc      = bus.PC;
    e_valid = !RESET && !loading && (pc % 4 == 0) && (pc < 32'(4 * prog.size()));
    e_instr = e_valid ? prog[pc / 4] : FILL;
    e_mis   = !RESET && (pc % 4 != 0);
    @(posedge CLK);
    #1;
    if (RESET) begin
      loading = 1'b0;
      prog.delete();
      pend.delete();
    end else if (bus.LOAD_START) begin
      loading = 1'b1;
      prog.delete();
      pend.delete();
    end else if (loading && bus.LOAD_VALID) begin
      pend.push_back(bus.LOAD_DATA);
      if (bus.LOAD_LAST || pend.size() == DEPTH) begin
        prog    = pend;
        loading = 1'b0;
      end
    end
    check("instruction", bus.INSTRUCTION, e_instr);
    check("instr_valid", 32'(bus.INSTR_VALID), 32'(e_valid));
    check("misalign",    32'(bus.MISALIGN),    32'(e_mis));
    check("load_ready",  32'(bus.LOAD_READY),  32'(loading));
    check("prog_len",    32'(bus.PROG_LEN),    32'(prog.size()));
  endtask

  task automatic idle_inputs();
    bus.LOAD_START = 1'b0;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_DATA  = '0;
    bus.LOAD_LAST  = 1'b0;
  endtask

  task automatic start_load();
    idle_inputs();
    bus.LOAD_START = 1'b1;
    cycle();
    bus.LOAD_START = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_DATA  = data;
    bus.LOAD_LAST  = last;
    cycle();
    idle_inputs();
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.PC = pc;
    cycle();
  endtask

  logic [31:0] six [6];
  logic [31:0] stream [20];
  int          accepted;

  initial begin
    six = '{32'h0000_002A, 32'h0101_0000, 32'h0202_0100,
            32'h0303_0200, 32'h0404_0300, 32'h0505_0400};
    idle_inputs();
    bus.PC = '0;
    RESET  = 1'b1;
    cycle();
    cycle();
    RESET = 1'b0;

    // Reset state observed through a fetch of PC=0.
    fetch(32'd0);
    check("reset_fill", bus.INSTRUCTION, FILL);
    check("reset_prog_len", 32'(bus.PROG_LEN), 32'd0);

    // Six-word program with LOAD_LAST on the sixth.
    start_load();
    for (int i = 0; i < 6; i++) send_word(six[i], i == 5);
    check("six_prog_len", 32'(bus.PROG_LEN), 32'd6);
    for (int i = 0; i < 6; i++) begin
      fetch(32'(4 * i));
      check("six_word", bus.INSTRUCTION, six[i]);
    end
    fetch(32'd24);
    check("past_end", bus.INSTRUCTION, FILL);
    fetch(32'd6);
    check("misalign_pc6", 32'(bus.MISALIGN), 32'd1);
    fetch(32'h0000_1000);
    check("high_pc", bus.INSTRUCTION, FILL);

    // Twenty words without LOAD_LAST: only DEPTH are taken.
    start_load();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      stream[i] = $urandom();
      if (bus.LOAD_READY) accepted++;
      send_word(stream[i], 1'b0);
    end
    check("stream_accepted", 32'(accepted), 32'(DEPTH));
    check("stream_ready_low", 32'(bus.LOAD_READY), 32'd0);
    check("stream_prog_len", 32'(bus.PROG_LEN), 32'(DEPTH));
    fetch(32'd60);
    check("stream_last_word", bus.INSTRUCTION, stream[DEPTH-1]);

    // Restart after three words, then a two-word program.
    start_load();
    for (int i = 0; i < 3; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_DATA  = 32'hDEAD_BEEF;
    start_load();
    send_word(32'h0111_2233, 1'b0);
    send_word(32'h0244_5566, 1'b1);
    check("restart_prog_len", 32'(bus.PROG_LEN), 32'd2);
    fetch(32'd0);
    check("restart_word0", bus.INSTRUCTION, 32'h0111_2233);
    fetch(32'd8);
    check("restart_pc8", bus.INSTRUCTION, FILL);

    // Reset in the middle of a load.
    start_load();
    for (int i = 0; i < 4; i++) send_word(32'hB000_0000 + 32'(i), 1'b0);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    check("midload_prog_len", 32'(bus.PROG_LEN), 32'd0);
    fetch(32'd0);
    check("midload_fill", bus.INSTRUCTION, FILL);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      RESET          = ($urandom_range(0, 199) == 0);
      bus.LOAD_START = ($urandom_range(0, 29) == 0);
      bus.LOAD_VALID = ($urandom_range(0, 9) < 7);
      bus.LOAD_DATA  = $urandom();
      bus.LOAD_LAST  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       bus.PC = $urandom();
        1, 2:    bus.PC = 32'($urandom_range(0, DEPTH * 4 + 15));
        default: bus.PC = 32'($urandom_range(0, DEPTH + 3) * 4);
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
